// File: rtl/out_port_pkg.sv
// out_port_pkg: shared defaults and sizing helpers for the output port bank.
// Imported by the interface, the per-channel FIFO and the bank top.
package out_port_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_DEPTH    = 4;

  // Bits needed to index n items, never less than one.
  function automatic int bits_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [DEF_WIDTH-1:0] out_word_t;

endpackage

// File: rtl/out_port_bank_if.sv
// out_port_bank_if: write port from execute plus the per-channel
// valid/ready output streams of the output port bank.
interface out_port_bank_if
  import out_port_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
);

  localparam int CHAN_W = bits_for(CHANNELS);

  logic                      wr_en;
  logic [CHAN_W-1:0]         wr_chan;
  logic [WIDTH-1:0]          wr_data;
  logic                      wr_accept;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;
  logic [CHANNELS-1:0]       full;
  logic [CHANNELS-1:0]       overflow;
  logic                      ovf_clr;

  modport master (
    output wr_en, wr_chan, wr_data,
    output out_ready, ovf_clr,
    input  wr_accept, out_data,
    input  out_valid, full, overflow
  );

  modport slave (
    input  wr_en, wr_chan, wr_data,
    input  out_ready, ovf_clr,
    output wr_accept, out_data,
    output out_valid, full, overflow
  );

endinterface

// File: rtl/out_port_chan_fifo.sv
// out_port_chan_fifo: one output channel's word FIFO.
// Head word is zeroed whenever the FIFO is empty.
module out_port_chan_fifo
  import out_port_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full
);

  localparam int PW = bits_for(DEPTH);
  localparam int CW = bits_for(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally; count tracks occupancy.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case (1'b1)
        push && !pop: count <= count + CW'(1);
        pop && !push: count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign valid = (count != '0);
  assign full  = (count == CW'(DEPTH));
  assign rdata = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/out_port_bank.sv
// out_port_bank: buffered multi-channel OUT ports with valid/ready.
// OUT_PORT_OVERFLOW_EN enables the sticky per-channel overflow flags.
module out_port_bank
  import out_port_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DEPTH    = DEF_DEPTH
) (
  input  logic            clk,
  input  logic            nReset,
  out_port_bank_if.slave  bus
);

  localparam int CHAN_W = bits_for(CHANNELS);

  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] pop;
  logic [CHANNELS-1:0] drop;
  logic [CHANNELS-1:0] valid;
  logic [CHANNELS-1:0] full;
  logic [WIDTH-1:0]    head [CHANNELS];

  assign pop = valid & bus.out_ready;

  // Decode the write to a channel; a full port without a pop drops it.
  always_comb begin
    push = '0;
    drop = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.wr_en && bus.wr_chan == CHAN_W'(c)) begin
        if (!full[c] || pop[c]) push[c] = 1'b1;
        else                    drop[c] = 1'b1;
      end
    end
  end

  assign bus.wr_accept = |push;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    out_port_chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk    (clk),
      .nReset (nReset),
      .push   (push[c]),
      .pop    (pop[c]),
      .wdata  (bus.wr_data),
      .rdata  (head[c]),
      .valid  (valid[c]),
      .full   (full[c])
    );
  end

  // Pack per-channel head words into the flat output bus.
  always_comb begin
    bus.out_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      bus.out_data[c*WIDTH +: WIDTH] = head[c];
    end
  end

  assign bus.out_valid = valid;
  assign bus.full      = full;

`ifdef OUT_PORT_OVERFLOW_EN
  logic [CHANNELS-1:0] ovf;

  // Sticky drop flags; a drop in the clearing cycle survives.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)          ovf <= '0;
    else if (bus.ovf_clr) ovf <= drop;
    else                  ovf <= ovf | drop;
  end

  assign bus.overflow = ovf;
`else
  logic unused_ovf;
  assign unused_ovf   = ^{drop, bus.ovf_clr};
  assign bus.overflow = '0;
`endif

endmodule

// File: tb/tb_out_port_bank.sv
// tb_out_port_bank: directed checks of the output port bank.
// Overflow expectations follow OUT_PORT_OVERFLOW_EN.
module tb_out_port_bank;

`ifdef OUT_PORT_OVERFLOW_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic clk = 1'b0;
  logic nReset;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  out_port_bank_if #(.WIDTH(16), .CHANNELS(4)) b ();
  out_port_bank_if #(.WIDTH(16), .CHANNELS(3)) b3 ();

  out_port_bank #(.WIDTH(16), .CHANNELS(4), .DEPTH(4)) u_dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (b)
  );

  out_port_bank #(.WIDTH(16), .CHANNELS(3), .DEPTH(4)) u_dut3 (
    .clk    (clk),
    .nReset (nReset),
    .bus    (b3)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [1:0] c,
                           input logic [15:0] d,
                           input logic exp_acc,
                           input string tag);
    b.wr_en   = 1'b1;
    b.wr_chan = c;
    b.wr_data = d;
    #1;
    chk(tag, 64'(b.wr_accept), 64'(exp_acc));
    tick();
    b.wr_en = 1'b0;
  endtask

  function automatic logic [15:0] slice(input int n);
    logic [63:0] v;
    v = b.out_data;
    return v[16*n +: 16];
  endfunction

  initial begin
    nReset      = 1'b0;
    b.wr_en     = 1'b0;
    b.wr_chan   = '0;
    b.wr_data   = '0;
    b.out_ready = '0;
    b.ovf_clr   = 1'b0;
    b3.wr_en    = 1'b0;
    b3.wr_chan  = '0;
    b3.wr_data  = '0;
    b3.out_ready = '0;
    b3.ovf_clr  = 1'b0;
    #1;
    chk("rst_valid", 64'(b.out_valid), 64'h0);
    chk("rst_full",  64'(b.full),      64'h0);
    chk("rst_ovf",   64'(b.overflow),  64'h0);
    chk("rst_data",  b.out_data,       64'h0);
    tick();
    tick();
    nReset = 1'b1;
    tick();

    // single write to channel 2
    push_word(2'd2, 16'hA5A5, 1'b1, "ch2_acc");
    chk("ch2_valid", 64'(b.out_valid), 64'h4);
    chk("ch2_data",  b.out_data, 64'h0000_A5A5_0000_0000);
    b.out_ready = 4'b0100;
    tick();
    b.out_ready = 4'b0000;
    chk("ch2_drained", 64'(b.out_valid), 64'h0);

    // fill channel 0, overflow, drain in order
    for (int i = 1; i <= 4; i++)
      push_word(2'd0, 16'(i), 1'b1, "fill0_acc");
    chk("fill0_full", 64'(b.full), 64'h1);
    chk("fill0_head", 64'(slice(0)), 64'h1);
    push_word(2'd0, 16'd5, 1'b0, "drop0_acc");
    chk("drop0_ovf",  64'(b.overflow), OVF ? 64'h1 : 64'h0);
    chk("drop0_full", 64'(b.full), 64'h1);
    b.out_ready = 4'b0001;
    for (int i = 1; i <= 4; i++) begin
      chk("drain0_data", 64'(slice(0)), 64'(i));
      tick();
    end
    b.out_ready = 4'b0000;
    chk("drain0_valid", 64'(b.out_valid), 64'h0);
    chk("drain0_full",  64'(b.full), 64'h0);

    // clear overflow
    b.ovf_clr = 1'b1;
    tick();
    b.ovf_clr = 1'b0;
    chk("clr_ovf", 64'(b.overflow), 64'h0);

    // full channel 1 with simultaneous push and pop
    for (int i = 0; i < 4; i++)
      push_word(2'd1, 16'h0010 + 16'(i), 1'b1, "fill1_acc");
    chk("fill1_full", 64'(b.full), 64'h2);
    b.out_ready = 4'b0010;
    push_word(2'd1, 16'h0077, 1'b1, "pp1_acc");
    chk("pp1_full", 64'(b.full), 64'h2);
    chk("pp1_ovf",  64'(b.overflow), 64'h0);
    chk("pp1_d0", 64'(slice(1)), 64'h0011);
    tick();
    chk("pp1_d1", 64'(slice(1)), 64'h0012);
    tick();
    chk("pp1_d2", 64'(slice(1)), 64'h0013);
    tick();
    chk("pp1_d3", 64'(slice(1)), 64'h0077);
    tick();
    chk("pp1_empty", 64'(b.out_valid), 64'h0);
    b.out_ready = 4'b0000;

    // channel 0 stalled full while channel 3 streams
    for (int i = 0; i < 4; i++)
      push_word(2'd0, 16'h0021 + 16'(i), 1'b1, "fill0b_acc");
    b.out_ready = 4'b1000;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        push_word(2'd3, 16'h0030 + 16'(k / 2), 1'b1, "il3_acc");
      end else begin
        chk("il3_data", 64'(slice(3)), 64'h0030 + 64'(k / 2));
        push_word(2'd0, 16'hDEAD, 1'b0, "il0_acc");
      end
    end
    b.out_ready = 4'b0000;
    chk("il_valid", 64'(b.out_valid), 64'h1);
    chk("il_head0", 64'(slice(0)), 64'h0021);
    chk("il_ovf",   64'(b.overflow), OVF ? 64'h1 : 64'h0);

    // drop in the same cycle as clear keeps the bit
    b.ovf_clr = 1'b1;
    push_word(2'd0, 16'hBEEF, 1'b0, "dc_acc");
    chk("dc_ovf", 64'(b.overflow), OVF ? 64'h1 : 64'h0);
    tick();
    b.ovf_clr = 1'b0;
    chk("dc_clr", 64'(b.overflow), 64'h0);
    b.out_ready = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      chk("drain0b_data", 64'(slice(0)), 64'h0021 + 64'(i));
      tick();
    end
    b.out_ready = 4'b0000;
    chk("drain0b_valid", 64'(b.out_valid), 64'h0);

    // reset mid-stream
    for (int i = 0; i < 4; i++)
      push_word(2'd0, 16'h0031 + 16'(i), 1'b1, "fill0c_acc");
    push_word(2'd0, 16'h0035, 1'b0, "drop0c_acc");
    for (int i = 0; i < 3; i++)
      push_word(2'd1, 16'h0101 + 16'(i), 1'b1, "q1_acc");
    chk("pre_rst_valid", 64'(b.out_valid), 64'h3);
    nReset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(b.out_valid), 64'h0);
    chk("mid_rst_full",  64'(b.full), 64'h0);
    chk("mid_rst_ovf",   64'(b.overflow), 64'h0);
    chk("mid_rst_data",  b.out_data, 64'h0);
    tick();
    nReset = 1'b1;
    tick();
    push_word(2'd1, 16'h0200, 1'b1, "post_rst_acc");
    chk("post_rst_valid", 64'(b.out_valid), 64'h2);
    chk("post_rst_data",  b.out_data, 64'h0000_0000_0200_0000);

    // three-channel bank: out-of-range channel is ignored
    b3.wr_en   = 1'b1;
    b3.wr_chan = 2'd2;
    b3.wr_data = 16'h0C0C;
    #1;
    chk("c3_acc", 64'(b3.wr_accept), 64'h1);
    tick();
    chk("c3_valid", 64'(b3.out_valid), 64'h4);
    chk("c3_data",  64'(b3.out_data), 64'h0C0C_0000_0000);
    b3.wr_chan = 2'd3;
    b3.wr_data = 16'hFFFF;
    #1;
    chk("c3_bad_acc", 64'(b3.wr_accept), 64'h0);
    tick();
    b3.wr_en = 1'b0;
    chk("c3_bad_valid", 64'(b3.out_valid), 64'h4);
    chk("c3_bad_full",  64'(b3.full), 64'h0);
    chk("c3_bad_ovf",   64'(b3.overflow), 64'h0);
    chk("c3_bad_data",  64'(b3.out_data), 64'h0C0C_0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
